layer_mac_scheduler: RTL
========================

Name: layer_mac_scheduler

Overview:
- Time-multiplexed fully-connected layer engine: one shared multiply-accumulate unit computes N_OUT ReLU neurons of N_IN inputs each, in place of one hard-wired node per neuron.
- Loads an activation vector over a valid/ready stream and fetches weights and biases from an external synchronous weight memory.
- Emits one 16-bit ReLU result per neuron over a valid/ready stream.
- Sits between consecutive layers of the ECG inference chain; a top-level sequencer starts it once per sample window.

Parameters:
- N_IN, 15, inputs per neuron (activation buffer depth)
- N_OUT, 16, neurons computed per start
- DW, 16, data/weight width, signed two's complement
- FRAC, 8, fractional bits of the Q(DW-FRAC).FRAC format for activations, weights and bias
- ACC_W, 40, accumulator width
- AW, clog2(N_OUT*(N_IN+1)), weight memory address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin one layer pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last output handshake
- in_valid  in  1  activation word valid
- in_ready  out  1  high only in LOAD
- in_data  in  DW  activation word, index order 0..N_IN-1
- w_en  out  1  weight memory read enable
- w_addr  out  AW  read address = neuron*(N_IN+1) + k; k = N_IN is the bias
- w_data  in  DW  read data, valid exactly one cycle after w_en
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  DW  ReLU result
- out_idx  out  clog2(N_OUT)  neuron index of out_data

Behaviour:
- Reset (reset=0, async): state IDLE. busy, done, in_ready, w_en, out_valid = 0. w_addr, out_data, out_idx = 0. Activation buffer and accumulator cleared.
- IDLE:
  - start=1 → LOAD, load counter = 0. busy rises the next cycle.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1; each in_valid&in_ready cycle writes buf[cnt] and increments cnt.
  - After word N_IN-1 is accepted → MAC, neuron n=0, k=0, acc=0.
- MAC, one read issued per cycle:
  - w_en=1, w_addr = n*(N_IN+1)+k, for k = 0..N_IN (N_IN+1 cycles).
  - Data returns one cycle later through a 1-stage pipeline carrying k.
  - For returned k < N_IN: acc += (buf[k]*w_data) >>> FRAC. The product is the full 2*DW signed value, arithmetic shift, sign-extended to ACC_W; no intermediate truncation to DW.
  - For returned k = N_IN: acc += sign-extended w_data (bias, same Q format).
  - w_en=0 in the drain cycle after the last issue.
  - Then → OUT, with out_data = ReLU(sat(acc)) registered.
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1]; ReLU maps negatives to 0. out_data is therefore in [0, 2^(DW-1)-1].
- OUT:
  - out_valid=1, out_idx=n; out_data and out_idx held stable while out_ready=0.
  - On handshake: if n = N_OUT-1 → DONE, else n++, k=0, acc=0 → MAC.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency per neuron: N_IN+2 cycles plus OUT, minimum 1 cycle (18 cycles with the defaults).
- Activation buffer is reused for all neurons; it is not reloaded per neuron.
- Reset mid-operation: immediate return to IDLE, all outputs as in reset. A weight read in flight is discarded.
- out_ready held high before OUT has no effect. in_valid outside LOAD is ignored, with no data consumed.

Decomposition:
- Package layer_pkg:
  - DW and FRAC defaults
  - state enum: IDLE, LOAD, MAC, OUT, DONE
  - sat_relu function: ACC_W in, DW out
  - address-computation helper
- Sub-module mac_unit:
  - Inputs: clear, en, is_bias, act, w.
  - Output: acc.
  - Holds the product, shift and accumulate logic so it can be reused by other layer engines.
- FSM, counters, buffer and handshakes stay in the top module.

Test Plan:
- Nominal, neuron 0: all 15 activations 0x0100 (1.0), neuron 0 weights all 0x0100, bias 0x0000 → out_idx=0, out_data=0x0F00; 16 outputs then a single done pulse; w_addr sequence 0..15 for neuron 0.
- ReLU clamp, neuron 1: weights 0xFF00 (-1.0), bias 0x0080 → out_data=0x0000 (sum -14.5 clamped to 0).
- Saturation: activations 0x7FFF, weights 0x7FFF, bias 0x7FFF → out_data=0x7FFF, no wrap to negative.
- Backpressure: out_ready low for 5 cycles in OUT → out_valid stays 1; out_data and out_idx unchanged; no w_en pulses until the handshake.
- Reset mid-MAC: reset=0 at k=7 of neuron 3 → same cycle busy=0, w_en=0, out_valid=0. A following start with fresh data gives correct neuron 0 results.
- Protocol: start pulsed while busy is ignored (single done per pass). in_valid stalls of 3 cycles during LOAD → still exactly 15 words accepted, and correct results.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared constants and helpers for the time-multiplexed layer engine.
// Holds the layer geometry, number format, FSM state encodings, the
// saturating ReLU used on the accumulator, and the weight address map.
package layer_pkg;

  localparam int unsigned N_IN  = 15;
  localparam int unsigned N_OUT = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned AW    = $clog2(N_OUT * (N_IN + 1));
  // k runs 0..N_IN inclusive (N_IN selects the bias word)
  localparam int unsigned KW    = $clog2(N_IN + 1);
  localparam int unsigned NW    = $clog2(N_OUT);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_MAC  = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Clamp to the signed DW range, then zero out negatives.
  function automatic logic [DW-1:0] sat_relu(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] max_v;
    max_v = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    if (a[ACC_W-1])   return '0;
    else if (a > max_v) return {1'b0, {(DW-1){1'b1}}};
    else              return a[DW-1:0];
  endfunction

  // Weight memory layout: N_IN weights followed by one bias per neuron.
  function automatic logic [AW-1:0] w_addr_of(input logic [NW-1:0] n,
                                              input logic [KW-1:0] k);
    return AW'(n) * AW'(N_IN + 1) + AW'(k);
  endfunction

endpackage

// File: rtl/layer_mac_scheduler_if.sv
// Stream and memory signals of the layer engine.
//   in_*  : activation stream (valid/ready), engine is the sink
//   w_*   : synchronous weight memory read port, data one cycle after w_en
//   out_* : result stream (valid/ready) with neuron index
// master = engine side, slave = environment side.
interface layer_mac_scheduler_if;
  import layer_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [NW-1:0] out_idx;

  modport master (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_en, w_addr, out_valid, out_data, out_idx
  );

  modport slave (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_en, w_addr, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/mac_unit.sv
// Signed multiply-accumulate for fixed-point layer engines.
//   clear   : zero the accumulator (priority over en)
//   en      : add one term this cycle
//   is_bias : term is w itself instead of (act*w) >>> FRAC
//   act, w  : signed DW-bit operands in the shared Q format
//   acc_c   : accumulator value including this cycle's term
module mac_unit
  import layer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    is_bias,
  input  logic signed [DW-1:0]    act,
  input  logic signed [DW-1:0]    w,
  output logic signed [ACC_W-1:0] acc_c
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0]  prod;
  logic signed [2*DW-1:0]  prod_sh;
  logic signed [ACC_W-1:0] term;

  // Full-width product, rescaled once; no truncation before accumulation.
  always_comb begin
    prod    = act * w;
    prod_sh = prod >>> FRAC;
    term    = is_bias ? ACC_W'(w) : ACC_W'(prod_sh);
    acc_d   = acc_q;
    if (clear)   acc_d = '0;
    else if (en) acc_d = acc_q + term;
  end

  assign acc_c = acc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/layer_mac_scheduler.sv
// Fully-connected ReLU layer computed on one shared MAC.
//   clk, reset (async, active low)
//   start : begin a pass (only honoured in IDLE)
//   busy  : high outside IDLE
//   done  : one-cycle pulse after the last result is accepted
//   bus   : activation in-stream, weight memory port, result out-stream
// Flow: LOAD N_IN activations, then per neuron issue N_IN+1 weight reads
// (last one is the bias), drain one cycle, present ReLU(sat(acc)) in OUT.
module layer_mac_scheduler
  import layer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  layer_mac_scheduler_if.master bus
);

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [KW-1:0] ik_q, ik_d;      // k of the read currently issued
  logic          rvalid_q, rvalid_d;
  logic [KW-1:0] rk_q, rk_d;      // k of the word on w_data
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_ready_q, in_ready_d;
  logic          w_en_q, w_en_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [NW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] act_buf_q [N_IN];
  logic [DW-1:0] act_buf_d [N_IN];

  logic                    mac_clear;
  logic                    mac_bias;
  logic signed [DW-1:0]    act_sel;
  logic signed [DW-1:0]    w_s;
  logic signed [ACC_W-1:0] acc_c;

  assign w_s = $signed(bus.w_data);

  mac_unit u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (mac_clear),
    .en      (rvalid_q),
    .is_bias (mac_bias),
    .act     (act_sel),
    .w       (w_s),
    .acc_c   (acc_c)
  );

  // Next-state, counters, buffer writes and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    ik_d        = ik_q;
    act_buf_d   = act_buf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_d  = in_ready_q;
    w_en_d      = 1'b0;
    w_addr_d    = w_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    mac_clear   = 1'b0;
    rvalid_d    = w_en_q;
    rk_d        = ik_q;
    mac_bias    = (rk_q == KW'(N_IN));
    act_sel     = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (rk_q == KW'(i)) act_sel = $signed(act_buf_q[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          cnt_d      = '0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end

      ST_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          for (int i = 0; i < N_IN; i++) begin
            if (cnt_q == KW'(i)) act_buf_d[i] = bus.in_data;
          end
          cnt_d = KW'(cnt_q + 1'b1);
          if (cnt_q == KW'(N_IN - 1)) begin
            state_d    = ST_MAC;
            in_ready_d = 1'b0;
            n_d        = '0;
            ik_d       = '0;
            w_en_d     = 1'b1;
            w_addr_d   = w_addr_of('0, '0);
            mac_clear  = 1'b1;
          end
        end
      end

      ST_MAC: begin
        // Keep issuing until the bias read has gone out.
        if (w_en_q && (ik_q != KW'(N_IN))) begin
          w_en_d   = 1'b1;
          ik_d     = KW'(ik_q + 1'b1);
          w_addr_d = w_addr_of(n_q, KW'(ik_q + 1'b1));
        end
        // Bias returning means this is the drain cycle; acc_c is final.
        if (rvalid_q && mac_bias) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_data_d  = sat_relu(acc_c);
          out_idx_d   = n_q;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (n_q == NW'(N_OUT - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_MAC;
            n_d       = NW'(n_q + 1'b1);
            ik_d      = '0;
            w_en_d    = 1'b1;
            w_addr_d  = w_addr_of(NW'(n_q + 1'b1), '0);
            mac_clear = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      ik_q        <= '0;
      rvalid_q    <= 1'b0;
      rk_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      for (int i = 0; i < N_IN; i++) act_buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      ik_q        <= ik_d;
      rvalid_q    <= rvalid_d;
      rk_q        <= rk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      act_buf_q   <= act_buf_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

endmodule
